// File: rtl/mmio_uart_ctrl.sv
// MMIO controller that bridges core loads/stores to the UART RX/TX ready-valid ports.
// It also owns the cycle and retired-instruction counters.
module mmio_uart_ctrl #(
  parameter int CNT_W = 32,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OFF_W-1:0] io_addr,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic             instr_retire,
  input  logic [7:0]       rx_data_out,
  input  logic             rx_data_out_valid,
  output logic             rx_data_out_ready,
  output logic [7:0]       tx_data_in,
  output logic             tx_data_in_valid,
  input  logic             tx_data_in_ready,
  output logic [0:0]       tx_state
);

  // Handshakes: a byte moves on an edge where valid and ready are both high;
  // valid never drops and data never changes while waiting for ready.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(8'h00);
  localparam logic [OFF_W-1:0] OFF_RX     = OFF_W'(8'h04);
  localparam logic [OFF_W-1:0] OFF_TX     = OFF_W'(8'h08);
  localparam logic [OFF_W-1:0] OFF_CYC    = OFF_W'(8'h10);
  localparam logic [OFF_W-1:0] OFF_INSTRET = OFF_W'(8'h14);
  localparam logic [OFF_W-1:0] OFF_CNT_CLR = OFF_W'(8'h18);

  logic [0:0]       state;
  logic             tx_ovf;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             tx_wr;
  logic             cnt_clr;
  logic             status_rd;
  logic [31:0]      rdata_next;

  assign tx_state  = state;
  assign tx_wr     = io_wr && (io_addr == OFF_TX);
  assign cnt_clr   = io_wr && (io_addr == OFF_CNT_CLR);
  assign status_rd = io_rd && (io_addr == OFF_STATUS);

  // Pop only when a byte is actually present; held low during reset.
  assign rx_data_out_ready = rst_n && io_rd && (io_addr == OFF_RX) && rx_data_out_valid;

  always_comb begin
    rdata_next = io_rdata;
    if (io_rd) begin
      case (io_addr)
        OFF_STATUS:  rdata_next = {29'b0, tx_ovf, rx_data_out_valid, state == ST_IDLE};
        OFF_RX:      rdata_next = {24'b0, rx_data_out};
        OFF_CYC:     rdata_next = 32'(cyc_cnt);
        OFF_INSTRET: rdata_next = 32'(ret_cnt);
        default:     rdata_next = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= 32'b0;
    end else begin
      io_rdata <= rdata_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      tx_data_in       <= 8'b0;
      tx_data_in_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_wr) begin
            tx_data_in       <= io_wdata[7:0];
            tx_data_in_valid <= 1'b1;
            state            <= ST_SEND;
          end
        end
        default: begin
          if (tx_data_in_ready) begin
            tx_data_in_valid <= 1'b0;
            state            <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // A dropped byte beats a simultaneous status-read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
    end else if (tx_wr && (state == ST_SEND)) begin
      tx_ovf <= 1'b1;
    end else if (status_rd) begin
      tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (instr_retire) ret_cnt <= ret_cnt + 1'b1;
    end
  end

endmodule
